// File: rtl/modu_ampl_scaler_if.sv
`default_nettype none
// ============================================================================
//  Module   : modu_ampl_scaler_if
//  Purpose  : Bundles the sample stream, the gain-control request and the
//             status returned by modu_ampl_scaler.
//  Modports : master - modulation generator / controller side
//                      (drives the sample, gain request and bypass)
//             slave  - the amplitude scaler itself
//  Signals  : dac_modu[DW], modu_valid, gain_target[GW], gain_load, bypass,
//             dac_modu_ampl[DW], ampl_valid, ampl_sat, gain_cur[GW], gain_busy
//  Revision : 1.0 - initial release
// ============================================================================
interface modu_ampl_scaler_if #(
    parameter int DW = 12,
    parameter int GW = 8
) ();
    logic [DW-1:0] dac_modu;
    logic          modu_valid;
    logic [GW-1:0] gain_target;
    logic          gain_load;
    logic          bypass;
    logic [DW-1:0] dac_modu_ampl;
    logic          ampl_valid;
    logic          ampl_sat;
    logic [GW-1:0] gain_cur;
    logic          gain_busy;

    modport master (
        output dac_modu, modu_valid, gain_target, gain_load, bypass,
        input  dac_modu_ampl, ampl_valid, ampl_sat, gain_cur, gain_busy
    );

    modport slave (
        input  dac_modu, modu_valid, gain_target, gain_load, bypass,
        output dac_modu_ampl, ampl_valid, ampl_sat, gain_cur, gain_busy
    );
endinterface
`default_nettype wire

// File: rtl/modu_ampl_scaler.sv
`default_nettype none
// ============================================================================
//  Module   : modu_ampl_scaler
//  Purpose  : Amplitude control for the modulation DAC path. Offset-binary
//             samples are re-centred, multiplied by an unsigned Q1.(GW-1)
//             gain, re-biased and clamped to the DAC range. Gain changes ramp
//             one LSB every RAMP_DIV clocks so the amplitude never steps.
//  Ports    : clk  - system clock
//             rst  - synchronous reset, active-high
//             bus  - modu_ampl_scaler_if.slave (sample in/out, gain control,
//                    bypass, saturation and ramp status)
//  Latency  : 2 clocks, no backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module modu_ampl_scaler #(
    parameter int DW        = 12,
    parameter int GW        = 8,
    parameter int BIAS      = 2047,
    parameter int GAIN_INIT = 64,
    parameter int RAMP_DIV  = 4
) (
    input  logic               clk,
    input  logic               rst,
    modu_ampl_scaler_if.slave  bus
);

    // Product width: signed (DW+1) x unsigned GW, plus one spare bit so the
    // re-biased sum can never overflow before clamping.
    localparam int PW = DW + GW + 2;
    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic signed [PW-1:0] C_BIAS     = PW'(BIAS);
    localparam logic signed [PW-1:0] C_MAX      = PW'((1 << DW) - 1);
    localparam logic [CW-1:0]        C_CNT_LAST = CW'(RAMP_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Gain ramp FSM
    // ------------------------------------------------------------------
    state_t        r_state_q,    w_state_d;
    logic [GW-1:0] r_gain_cur_q, w_gain_cur_d;
    logic [GW-1:0] r_target_q,   w_target_d;
    logic [CW-1:0] r_cnt_q,      w_cnt_d;

    always_comb begin
        w_state_d    = r_state_q;
        w_gain_cur_d = r_gain_cur_q;
        w_target_d   = r_target_q;
        w_cnt_d      = r_cnt_q;
        case (r_state_q)
            ST_IDLE: begin
                if (bus.gain_load && (bus.gain_target != r_gain_cur_q)) begin
                    w_target_d = bus.gain_target;
                    w_cnt_d    = '0;
                    w_state_d  = ST_RAMP;
                end
            end
            ST_RAMP: begin
                // The step always heads toward the target held before this
                // clock; a simultaneous reload only takes effect afterwards.
                if (r_cnt_q == C_CNT_LAST) begin
                    w_cnt_d = '0;
                    if (r_target_q > r_gain_cur_q) begin
                        w_gain_cur_d = r_gain_cur_q + GW'(1);
                    end else if (r_target_q < r_gain_cur_q) begin
                        w_gain_cur_d = r_gain_cur_q - GW'(1);
                    end
                end else begin
                    w_cnt_d = r_cnt_q + CW'(1);
                end
                if (bus.gain_load) begin
                    w_target_d = bus.gain_target;
                end
                // Leave the ramp in the same clock that the gain lands on the
                // (possibly just reloaded) target.
                if (w_gain_cur_d == w_target_d) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_gain_cur_q <= GW'(GAIN_INIT);
            r_target_q   <= GW'(GAIN_INIT);
            r_cnt_q      <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_gain_cur_q <= w_gain_cur_d;
            r_target_q   <= w_target_d;
            r_cnt_q      <= w_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: re-centre and multiply
    // ------------------------------------------------------------------
    logic signed [DW:0]   w_s;
    logic signed [PW-1:0] w_s_ext;
    logic signed [PW-1:0] w_g_ext;

    logic signed [PW-1:0] r_p_q,   w_p_d;
    logic [DW-1:0]        r_raw_q, w_raw_d;
    logic                 r_byp_q, w_byp_d;
    logic                 r_v1_q,  w_v1_d;

    // Subtracting 2^(DW-1) from an offset-binary code is the same as
    // inverting its MSB; the inverted MSB is then the sign bit.
    assign w_s     = {~bus.dac_modu[DW-1], ~bus.dac_modu[DW-1], bus.dac_modu[DW-2:0]};
    assign w_s_ext = {{(PW-DW-1){w_s[DW]}}, w_s};
    assign w_g_ext = {{(PW-GW){1'b0}}, r_gain_cur_q};

    always_comb begin
        w_p_d   = r_p_q;
        w_raw_d = r_raw_q;
        w_byp_d = r_byp_q;
        w_v1_d  = bus.modu_valid;
        if (bus.modu_valid) begin
            w_p_d   = w_s_ext * w_g_ext;
            w_raw_d = bus.dac_modu;
            w_byp_d = bus.bypass;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: rescale, re-bias, clamp
    // ------------------------------------------------------------------
    logic signed [PW-1:0] w_q;
    logic signed [PW-1:0] w_r;

    logic [DW-1:0] r_ampl_q,  w_ampl_d;
    logic          r_sat_q,   w_sat_d;
    logic          r_valid_q, w_valid_d;

    assign w_q = r_p_q >>> (GW - 1);
    assign w_r = w_q + C_BIAS;

    always_comb begin
        w_ampl_d  = r_ampl_q;
        w_sat_d   = r_sat_q;
        w_valid_d = r_v1_q;
        if (r_v1_q) begin
            if (r_byp_q) begin
                w_ampl_d = r_raw_q;
                w_sat_d  = 1'b0;
            end else if (w_r < 0) begin
                w_ampl_d = '0;
                w_sat_d  = 1'b1;
            end else if (w_r > C_MAX) begin
                w_ampl_d = '1;
                w_sat_d  = 1'b1;
            end else begin
                w_ampl_d = w_r[DW-1:0];
                w_sat_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_q     <= '0;
            r_raw_q   <= '0;
            r_byp_q   <= 1'b0;
            r_v1_q    <= 1'b0;
            r_ampl_q  <= DW'(BIAS);
            r_sat_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_p_q     <= w_p_d;
            r_raw_q   <= w_raw_d;
            r_byp_q   <= w_byp_d;
            r_v1_q    <= w_v1_d;
            r_ampl_q  <= w_ampl_d;
            r_sat_q   <= w_sat_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign bus.dac_modu_ampl = r_ampl_q;
    assign bus.ampl_valid    = r_valid_q;
    assign bus.ampl_sat      = r_sat_q;
    assign bus.gain_cur      = r_gain_cur_q;
    assign bus.gain_busy     = (r_state_q == ST_RAMP);

endmodule
`default_nettype wire
